instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Parametrised instruction fetch stage for the RISC-V core: a byte-organised instruction memory loaded through a word write port, a PC register with sequential advance and redirect, and a registered valid/ready output to decode. It adds a load/run/halt state machine, decode backpressure, branch/jump redirection and fault reporting for misaligned or out-of-range fetches.

## Interface
- MEM_BYTES, 64, instruction memory size in bytes; multiple of 4
- PC_W, 32, width of all PC/address ports
- RESET_PC, 0, PC loaded at reset and on start; word aligned
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse; IDLE -> RUN
- ld_we  in  1  memory word write enable (honoured in IDLE only)
- ld_addr  in  PC_W  byte address of word; bits [1:0] ignored
- ld_data  in  32  word to write, little-endian
- redir_valid  in  1  redirect request (branch/jump taken)
- redir_pc  in  PC_W  redirect target
- out_ready  in  1  decode can accept
- out_valid  out  1  out_instr/out_pc hold a fetched word
- out_instr  out  32  instruction word
- out_pc  out  PC_W  address of out_instr
- running  out  1  state == RUN
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 misaligned redirect, 2 out-of-range fetch

## Operation
- States: IDLE, RUN, HALT. Reset (reset==0 at an edge) -> IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_code=0, running=0. Memory contents are not cleared by reset.
- IDLE: ld_we writes bytes mem[a..a+3] = ld_data[7:0..31:24], a = {ld_addr[PC_W-1:2],2'b00}; writes with a+3 >= MEM_BYTES ignored. start -> RUN, pc=RESET_PC. redir_valid ignored.
- RUN: ld_we and start ignored. A fetch happens when out_valid==0 or out_ready==1 and no redirect: out_instr={mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}, out_pc=pc, out_valid=1, pc=pc+4 (PC_W wrap).
- Fetch attempt with pc+4 > MEM_BYTES: no fetch; fault=1, fault_code=2, -> HALT. If a word was accepted in the same cycle, out_valid=0.
- Redirect (RUN, redir_valid=1) has priority over fetch: out_valid=0 (flush), pc=redir_pc, no fetch that cycle. A transfer (out_valid&&out_ready) in that same cycle still counts as delivered.
- redir_pc[1:0]!=0: pc unchanged, out_valid=0, fault=1, fault_code=1, -> HALT.
- In-range checking of a redirect target happens at the next fetch attempt, not at redirect.
- HALT: no fetches, redirects ignored; out_valid stays until handshake then drops; fault/fault_code hold. Exit only via reset.
- Holding: while out_valid=1 and out_ready=0, out_instr/out_pc stable.

## Timing
- start sampled at edge N -> running=1 after N; first fetch at edge N+1 -> out_valid=1, out_pc=RESET_PC after N+1.
- out_ready held high: one word per cycle, PCs RESET_PC, +4, +8, ...
- Redirect sampled at edge E -> out_valid=0 after E; out_pc=target, out_valid=1 after E+1 (one bubble).
- Faults visible the cycle after the offending edge.
- reset low at any edge overrides everything, including mid-fetch or mid-redirect.

## Test plan
- Load 9 words at 0..32 (0x007302b3, 0x41248433, 0x01ac9c33, 0x01eede33, 0x016aea33, 0x013975b3, 0x00d675b3, 0x007302b3, 0x00d675b3), start, out_ready=1 -> 9 consecutive words with out_pc 0..32, then out_pc 32+4 attempt with MEM_BYTES=36 -> fault_code=2, HALT, out_valid=0.
- out_ready low for 3 cycles with out_valid=1 at pc 8 -> out_instr=0x01ac9c33 stable, no PC advance; release -> pc 12 next.
- Redirect to 0x14 while out_pc=4 -> one bubble, next out_pc=0x14, out_instr=0x013975b3.
- Redirect to 0x06 -> fault=1, fault_code=1, out_valid=0, no further fetches; redir/start ignored until reset.
- ld_we during RUN -> memory unchanged; reset mid-run -> IDLE, outputs zero, restart re-fetches identical words.
- Redirect and handshake in same cycle -> word counted delivered, next word from target.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | instr_fetch_unit                                                            |
// | Byte-organised instruction memory with load/run/halt fetch sequencing.      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int              MEM_BYTES = 64,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_we,
  input  logic [PC_W-1:0] ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            running,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int XW = PC_W + 1;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic [7:0]      mem_q [MEM_BYTES];

  logic [PC_W-1:0] ld_word_addr;
  logic            ld_in_range;
  logic            mem_we;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            fetch_in_range;
  logic            xfer;
  logic            can_fetch;

  // Range checks are done one bit wider than the PC so pc+4 cannot wrap.
  always_comb begin
    ld_word_addr   = ld_addr & ~PC_W'(3);
    ld_in_range    = ({1'b0, ld_word_addr} + XW'(4)) <= XW'(MEM_BYTES);
    mem_we         = reset && (state_q == ST_IDLE) && ld_we && ld_in_range;
    wr_idx         = ld_word_addr[AW-1:0];
    rd_idx         = pc_q[AW-1:0];
    fetch_in_range = ({1'b0, pc_q} + XW'(4)) <= XW'(MEM_BYTES);
    rd_word        = '0;
    for (int k = 0; k < 4; k++) begin
      rd_word[8*k +: 8] = mem_q[rd_idx + AW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[wr_idx + AW'(k)] <= ld_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    xfer         = out_valid_q && out_ready;
    can_fetch    = !out_valid_q || out_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_RUN: begin
        // Redirect wins over fetch; a word handed over this cycle is still delivered.
        if (redir_valid) begin
          out_valid_d = 1'b0;
          if (redir_pc[1:0] != 2'b00) begin
            fault_d      = 1'b1;
            fault_code_d = FAULT_MISALIGN;
            state_d      = ST_HALT;
          end else begin
            pc_d = redir_pc;
          end
        end else if (can_fetch) begin
          if (!fetch_in_range) begin
            out_valid_d  = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = FAULT_RANGE;
            state_d      = ST_HALT;
          end else begin
            out_instr_d = rd_word;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PC_W'(4);
          end
        end
      end

      ST_HALT: begin
        if (xfer) begin
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  assign running    = (state_q == ST_RUN);
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_instr_fetch_unit                                                         |
// | Directed self-checking bench for instr_fetch_unit (MEM_BYTES = 36).         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam int MEM_BYTES = 36;
  localparam int PC_W      = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            ld_we;
  logic [PC_W-1:0] ld_addr;
  logic [31:0]     ld_data;
  logic            redir_valid;
  logic [PC_W-1:0] redir_pc;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            running;
  logic            fault;
  logic [1:0]      fault_code;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] words [9];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .MEM_BYTES (MEM_BYTES),
    .PC_W      (PC_W),
    .RESET_PC  (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .running     (running),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    start       = 1'b0;
    ld_we       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic start_run();
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({out_valid, out_instr, out_pc, running, fault, fault_code} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b instr=%h pc=%h run=%0b fault=%0b code=%0d, expected all zero",
               out_valid, out_instr, out_pc, running, fault, fault_code);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 9; i++) begin
      ld_we   = 1'b1;
      ld_addr = (i == 8) ? 32'h22 : 32'(4 * i);
      ld_data = words[i];
      tick();
    end
    // Out-of-range writes that would alias onto low addresses if not rejected
    ld_addr = 32'h40; ld_data = 32'hffff_ffff; tick();
    ld_addr = 32'h24; ld_data = 32'heeee_eeee; tick();
    ld_we = 1'b0;
    tests_run++;
    if ({running, out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_during_load: got run=%0b v=%0b, expected run=0 v=0", running, out_valid);
    end
  endtask

  task automatic test_stream();
    start_run();
    tests_run++;
    if ({running, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL start_latency: got run=%0b v=%0b, expected run=1 v=0", running, out_valid);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * i), words[i]}) begin
        tests_failed++;
        $display("FAIL stream_word%0d: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), words[i]);
      end
    end
    tick();
    tests_run++;
    if ({out_valid, running, fault, fault_code} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
      tests_failed++;
      $display("FAIL range_fault: got v=%0b run=%0b fault=%0b code=%0d, expected v=0 run=0 fault=1 code=2",
               out_valid, running, fault, fault_code);
    end
    tick();
    tick();
    tests_run++;
    if ({out_valid, running, fault, fault_code} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
      tests_failed++;
      $display("FAIL halt_sticky: got v=%0b run=%0b fault=%0b code=%0d, expected v=0 run=0 fault=1 code=2",
               out_valid, running, fault, fault_code);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    start_run();
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h8, 32'h01ac9c33}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got v=%0b pc=%h instr=%h, expected v=1 pc=00000008 instr=01ac9c33",
                 i, out_valid, out_pc, out_instr);
      end
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'hc, 32'h01eede33}) begin
      tests_failed++;
      $display("FAIL release_next: got v=%0b pc=%h instr=%h, expected v=1 pc=0000000c instr=01eede33",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    start_run();
    tick();
    tick();
    tests_run++;
    if ({out_valid, out_pc} !== {1'b1, 32'h4}) begin
      tests_failed++;
      $display("FAIL pre_redirect: got v=%0b pc=%h, expected v=1 pc=00000004", out_valid, out_pc);
    end
    redir_valid = 1'b1;
    redir_pc    = 32'h14;
    tick();
    redir_valid = 1'b0;
    tests_run++;
    if ({out_valid, running} !== 2'b01) begin
      tests_failed++;
      $display("FAIL redirect_bubble: got v=%0b run=%0b, expected v=0 run=1", out_valid, running);
    end
    tick();
    tests_run++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h14, 32'h013975b3}) begin
      tests_failed++;
      $display("FAIL redirect_target: got v=%0b pc=%h instr=%h, expected v=1 pc=00000014 instr=013975b3",
               out_valid, out_pc, out_instr);
    end
    tick();
    tests_run++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h18, 32'h00d675b3}) begin
      tests_failed++;
      $display("FAIL redirect_follow: got v=%0b pc=%h instr=%h, expected v=1 pc=00000018 instr=00d675b3",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    // Word at 0x18 is accepted on the same edge the redirect to 0x0 is taken
    redir_valid = 1'b1;
    redir_pc    = 32'h0;
    tick();
    redir_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_flush: got v=%0b, expected v=0", out_valid);
    end
    tick();
    tests_run++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h007302b3}) begin
      tests_failed++;
      $display("FAIL b2b_target: got v=%0b pc=%h instr=%h, expected v=1 pc=00000000 instr=007302b3",
               out_valid, out_pc, out_instr);
    end
    // Aligned redirect past the end is accepted, then faults on the fetch attempt
    redir_valid = 1'b1;
    redir_pc    = 32'h24;
    tick();
    redir_valid = 1'b0;
    tests_run++;
    if ({out_valid, running, fault} !== 3'b010) begin
      tests_failed++;
      $display("FAIL late_range_redirect: got v=%0b run=%0b fault=%0b, expected v=0 run=1 fault=0",
               out_valid, running, fault);
    end
    tick();
    tests_run++;
    if ({out_valid, running, fault, fault_code} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
      tests_failed++;
      $display("FAIL late_range_fault: got v=%0b run=%0b fault=%0b code=%0d, expected v=0 run=0 fault=1 code=2",
               out_valid, running, fault, fault_code);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    start_run();
    tick();
    redir_valid = 1'b1;
    redir_pc    = 32'h6;
    tick();
    redir_valid = 1'b0;
    tests_run++;
    if ({fault, fault_code, out_valid, running} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL misalign_fault: got fault=%0b code=%0d v=%0b run=%0b, expected fault=1 code=1 v=0 run=0",
               fault, fault_code, out_valid, running);
    end
    redir_valid = 1'b1;
    redir_pc    = 32'h10;
    start       = 1'b1;
    tick();
    tick();
    redir_valid = 1'b0;
    start       = 1'b0;
    tests_run++;
    if ({fault, fault_code, out_valid, running, out_pc} !== {1'b1, 2'd1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL halt_ignores: got fault=%0b code=%0d v=%0b run=%0b pc=%h, expected fault=1 code=1 v=0 run=0 pc=00000000",
               fault, fault_code, out_valid, running, out_pc);
    end
  endtask

  task automatic test_run_write_and_reset();
    apply_reset();
    start_run();
    ld_we   = 1'b1;
    ld_addr = 32'h0;
    ld_data = 32'hdead_beef;
    tick();
    tick();
    ld_we = 1'b0;
    // Reset lands on the same edge as a redirect request
    reset       = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 32'h10;
    tick();
    tests_run++;
    if ({out_valid, out_instr, out_pc, running, fault, fault_code} !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset: got v=%0b instr=%h pc=%h run=%0b fault=%0b code=%0d, expected all zero",
               out_valid, out_instr, out_pc, running, fault, fault_code);
    end
    reset       = 1'b1;
    redir_valid = 1'b0;
    start_run();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * i), words[i]}) begin
        tests_failed++;
        $display("FAIL restart_word%0d: got v=%0b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 32'(4 * i), words[i]);
      end
    end
  endtask

  initial begin
    words[0] = 32'h007302b3;
    words[1] = 32'h41248433;
    words[2] = 32'h01ac9c33;
    words[3] = 32'h01eede33;
    words[4] = 32'h016aea33;
    words[5] = 32'h013975b3;
    words[6] = 32'h00d675b3;
    words[7] = 32'h007302b3;
    words[8] = 32'h00d675b3;

    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_run_write_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
